// File: rtl/pipe_stage_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_fifo_if
// Description : Handshake and payload bundle for the pipeline-stage FIFO.
//               The upstream side offers {data, ctrl, flags} with in_valid,
//               and the downstream side consumes the head with out_ready.
//               master = surrounding pipeline, slave = the FIFO itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_fifo_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*DATA_W-1:0]   in_data;
    logic [CTRL_W-1:0]     in_ctrl;
    logic [3:0]            in_flags;

    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   out_data;
    logic [CTRL_W-1:0]     out_ctrl;
    logic [3:0]            out_flags;

    modport master (
        output in_valid, in_data, in_ctrl, in_flags, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, out_flags
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, in_flags, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, out_flags
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_fifo
// Description : Circular elastic buffer between two pipeline stages. Holds
//               {alu_result, operand_b}, a control bundle and NZCV flags.
//               Supports a global freeze (halt), a discard-all (flush), an
//               occupancy output and a saturating downstream-stall counter.
//               Optional macro PIPE_STAGE_FIFO_BYPASS_EN adds a zero-latency
//               path from input to output when the buffer is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_fifo #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 2
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    halt,
    input  wire logic                    flush,
    pipe_stage_fifo_if.slave             bus,
    output logic [$clog2(DEPTH):0]       count,
    output logic [15:0]                  stall_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = 2*DATA_W + CTRL_W + 4;

    // Entry storage carries no reset; only pointers and counters are cleared.
    logic [c_ENT_W-1:0] mem_q [DEPTH];

    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q,  count_d;
    logic [15:0]        stall_q,  stall_d;

    logic               w_open;
    logic               w_held_valid;
    logic               w_bypass;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_skip;
    logic               w_store;
    logic               w_deq;
    logic [c_ENT_W-1:0] w_in_ent;
    logic [c_ENT_W-1:0] w_out_ent;

    assign w_open       = ~halt & ~flush;
    assign w_held_valid = (count_q != '0) & w_open;
    assign w_in_ent     = {bus.in_data, bus.in_ctrl, bus.in_flags};

`ifdef PIPE_STAGE_FIFO_BYPASS_EN
    assign w_bypass     = (count_q == '0) & bus.in_valid & w_open;
`else
    assign w_bypass     = 1'b0;
`endif

    assign w_out_valid  = w_held_valid | w_bypass;
    assign bus.in_ready = (count_q < c_CNT_W'(DEPTH)) & w_open;

    // A bypassed entry taken downstream in the same cycle never touches the
    // storage, so it neither advances the pointers nor changes the count.
    assign w_push       = bus.in_valid & bus.in_ready;
    assign w_pop        = w_out_valid & bus.out_ready;
    assign w_skip       = w_bypass & bus.out_ready;
    assign w_store      = w_push & ~w_skip;
    assign w_deq        = w_pop & ~w_skip;

    // Next-state for pointers, occupancy and stall counter (flush beats halt).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (!halt) begin
            if (w_store) begin
                wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_deq) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_store, w_deq})
                2'b10:   count_d = count_q + c_CNT_W'(1);
                2'b01:   count_d = count_q - c_CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (w_out_valid && !bus.out_ready && (stall_q != 16'hFFFF)) begin
                stall_d = stall_q + 16'd1;
            end
        end
    end

    // Control-state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Write the accepted entry into the slot under the write pointer.
    always_ff @(posedge clk) begin
        if (rst && w_store) begin
            mem_q[wr_ptr_q] <= w_in_ent;
        end
    end

    // Head selection; payload forced to zero whenever nothing is presented.
    always_comb begin
        w_out_ent = '0;
        if (w_held_valid) begin
            w_out_ent = mem_q[rd_ptr_q];
        end
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
        else if (w_bypass) begin
            w_out_ent = w_in_ent;
        end
`endif
    end

    assign bus.out_valid = w_out_valid;
    assign {bus.out_data, bus.out_ctrl, bus.out_flags} = w_out_ent;
    assign count     = count_q;
    assign stall_cnt = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_fifo
// Description : Self-checking bench for pipe_stage_fifo. Drives a DEPTH=2 and
//               a DEPTH=4 instance with identical stimulus and compares both
//               against queue-based reference models. Bypass expectations
//               follow PIPE_STAGE_FIFO_BYPASS_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_fifo;

    localparam int DW = 64;
    localparam int CW = 8;

    typedef struct packed {
        logic [2*DW-1:0] d;
        logic [CW-1:0]   c;
        logic [3:0]      f;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            halt;
    logic            flush;
    logic            in_valid;
    logic            out_ready;
    logic [2*DW-1:0] in_data;
    logic [CW-1:0]   in_ctrl;
    logic [3:0]      in_flags;

    logic [1:0]      cnt_a;
    logic [2:0]      cnt_b;
    logic [15:0]     st_a;
    logic [15:0]     st_b;

    always #5 clk = ~clk;

    pipe_stage_fifo_if #(.DATA_W(DW), .CTRL_W(CW)) ifa ();
    pipe_stage_fifo_if #(.DATA_W(DW), .CTRL_W(CW)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.in_ctrl   = in_ctrl;
    assign ifa.in_flags  = in_flags;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.in_ctrl   = in_ctrl;
    assign ifb.in_flags  = in_flags;
    assign ifb.out_ready = out_ready;

    pipe_stage_fifo #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(2)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .flush     (flush),
        .bus       (ifa.slave),
        .count     (cnt_a),
        .stall_cnt (st_a)
    );

    pipe_stage_fifo #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(4)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .flush     (flush),
        .bus       (ifb.slave),
        .count     (cnt_b),
        .stall_cnt (st_b)
    );

    // Reference state: the ordered list of held entries and the stall count.
    ent_t qa[$];
    ent_t qb[$];
    int   sa;
    int   sb;
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic ent_t in_ent();
        ent_t e;
        e.d = in_data;
        e.c = in_ctrl;
        e.f = in_flags;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [139:0] obs, input logic [139:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare one instance with its model, then advance the model by one edge.
    task automatic model_dut(input int k);
        ent_t        q[$];
        int          depth;
        int          st;
        logic [3:0]  oc;
        logic        oir;
        logic        oov;
        ent_t        oe;
        logic [15:0] ost;
        string       p;
        bit          byp;
        bit          ev;
        bit          eir;
        ent_t        eh;
        if (k == 0) begin
            q = qa; st = sa; depth = 2; p = "A";
            oc = {2'b00, cnt_a}; oir = ifa.in_ready; oov = ifa.out_valid;
            oe = {ifa.out_data, ifa.out_ctrl, ifa.out_flags}; ost = st_a;
        end else begin
            q = qb; st = sb; depth = 4; p = "B";
            oc = {1'b0, cnt_b}; oir = ifb.in_ready; oov = ifb.out_valid;
            oe = {ifb.out_data, ifb.out_ctrl, ifb.out_flags}; ost = st_b;
        end
        eir = (q.size() < depth) && !halt && !flush;
        byp = 1'b0;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
        byp = (q.size() == 0) && in_valid && !halt && !flush;
`endif
        ev = ((q.size() > 0) && !halt && !flush) || byp;
        eh = '0;
        if (ev) eh = (q.size() > 0) ? q[0] : in_ent();

        chk({p, "_count"},     140'(oc),   140'(q.size()));
        chk({p, "_in_ready"},  140'(oir),  140'(eir));
        chk({p, "_out_valid"}, 140'(oov),  140'(ev));
        chk({p, "_out_data"},  140'(oe.d), 140'(eh.d));
        chk({p, "_out_ctrl"},  140'(oe.c), 140'(eh.c));
        chk({p, "_out_flags"}, 140'(oe.f), 140'(eh.f));
        chk({p, "_stall_cnt"}, 140'(ost),  140'(st));

        if (!rst) begin
            q.delete();
            st = 0;
        end else if (flush) begin
            q.delete();
        end else if (!halt) begin
            if (ev && !out_ready && st < 65535) st++;
            if (!(byp && out_ready)) begin
                if (ev && out_ready) void'(q.pop_front());
                if (in_valid && eir) q.push_back(in_ent());
            end
        end

        if (k == 0) begin qa = q; sa = st; end
        else        begin qb = q; sb = st; end
    endtask

    task automatic step();
        @(negedge clk);
        model_dut(0);
        model_dut(1);
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [2*DW-1:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = d[7:0] ^ 8'h5A;
        in_flags = d[3:0];
    endtask

    initial begin
        rst = 1'b0; halt = 1'b0; flush = 1'b0; out_ready = 1'b0;
        offer(1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        qa.delete(); qb.delete(); sa = 0; sb = 0;
        rst = 1'b1;

        // Reset state: empty, ready, nothing presented.
        #1;
        chk("rst_in_ready",  140'(ifa.in_ready),  140'(1));
        chk("rst_out_valid", 140'(ifa.out_valid), 140'(0));
        chk("rst_count",     140'(cnt_a),         140'(0));
        step();

        // Fill the 2-deep buffer; the third offer must be refused.
        out_ready = 1'b0;
        offer(1'b1, 128'h1); step();
        offer(1'b1, 128'h2); step();
        offer(1'b1, 128'h3); #1;
        chk("full_count",    140'(cnt_a),        140'(2));
        chk("full_in_ready", 140'(ifa.in_ready), 140'(0));
        step();
        offer(1'b0, '0);

        // Drain: A then B, then empty with zeroed payload.
        out_ready = 1'b1; #1;
        chk("drain_head_A", 140'(ifa.out_data), 140'(128'h1));
        step();
        chk("drain_head_B", 140'(ifa.out_data), 140'(128'h2));
        step();
        chk("drain_empty_valid", 140'(ifa.out_valid), 140'(0));
        chk("drain_empty_data",  140'(ifa.out_data),  140'(0));
        step();

        // Ten pushes with continuous pops across the 4-deep pointer wrap.
        for (int i = 0; i < 10; i++) begin
            offer(1'b1, 128'(32'h100 + i));
            step();
            chk("wrap_count_le1", 140'(cnt_b <= 3'd1), 140'(1));
        end
        offer(1'b0, '0);
        step();
        step();

        // Flush with halt and a concurrent offer: everything gone.
        out_ready = 1'b0;
        offer(1'b1, 128'hAA); step();
        offer(1'b1, 128'hBB); step();
        halt = 1'b1; flush = 1'b1;
        offer(1'b1, 128'hDEAD);
        step();
        halt = 1'b0; flush = 1'b0;
        offer(1'b0, '0); #1;
        chk("flush_count_A",   140'(cnt_a),         140'(0));
        chk("flush_count_B",   140'(cnt_b),         140'(0));
        chk("flush_out_valid", 140'(ifa.out_valid), 140'(0));
        step();

        // Long downstream stall saturates the counter; reset then clears it.
        offer(1'b1, 128'h77); step();
        offer(1'b0, '0);
        repeat (70000) @(posedge clk);
        #1;
        sa = (sa + 70000 > 65535) ? 65535 : sa + 70000;
        sb = (sb + 70000 > 65535) ? 65535 : sb + 70000;
        chk("stall_sat", 140'(st_a), 140'(16'hFFFF));
        step();
        rst = 1'b0;
        step();
        rst = 1'b1; #1;
        chk("stall_rst",     140'(st_a),  140'(0));
        chk("stall_rst_cnt", 140'(cnt_a), 140'(0));
        step();

        // Randomized traffic, including occasional reset, halt and flush.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) != 0);
            halt      = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_ctrl   = 8'($urandom);
            in_flags  = 4'($urandom);
            step();
        end
        rst = 1'b1; halt = 1'b0; flush = 1'b0;

`ifdef PIPE_STAGE_FIFO_BYPASS_EN
        // Empty buffer, entry offered and consumed in the same cycle.
        offer(1'b0, '0); out_ready = 1'b0;
        rst = 1'b0; step();
        rst = 1'b1; step();
        offer(1'b1, 128'hAB); out_ready = 1'b1; #1;
        chk("byp_out_valid", 140'(ifa.out_valid), 140'(1));
        chk("byp_out_data",  140'(ifa.out_data),  140'(128'hAB));
        chk("byp_count",     140'(cnt_a),         140'(0));
        step();
        offer(1'b0, '0);
        chk("byp_count_after", 140'(cnt_a), 140'(0));
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_fifo.md
PIPE_STAGE_FIFO -- requirements
Module: pipe_stage_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of the data payload (ALU result / operand words).
REQ-002 SHALL have parameter CTRL_W, default 8: width of the stage-control bundle (regwrite, memwrite, memtoreg, branch, setflags, write address, ...).
REQ-003 SHALL have parameter DEPTH, default 2: number of entries; legal values 2, 4, 8.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port halt  in  1  global pipeline freeze.
REQ-007 SHALL have port flush  in  1  discard all held entries (branch mispredict / exception).
REQ-008 SHALL have port in_valid  in  1  upstream entry present.
REQ-009 SHALL have port in_ready  out  1  buffer accepts an entry this cycle.
REQ-010 SHALL have port in_data  in  2*DATA_W  {alu_result, operand_b}.
REQ-011 SHALL have port in_ctrl  in  CTRL_W  control bundle.
REQ-012 SHALL have port in_flags  in  4  NZCV flags.
REQ-013 SHALL have port out_valid  out  1  head entry presented downstream.
REQ-014 SHALL have port out_ready  in  1  downstream consumes the head.
REQ-015 SHALL have ports out_data (2*DATA_W), out_ctrl (CTRL_W) and out_flags (4), all outputs, forming the head entry.
REQ-016 SHALL have port count  out  clog2(DEPTH)+1  current occupancy.
REQ-017 SHALL have port stall_cnt  out  16  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-018 SHALL be a circular FIFO with read and write pointers that wrap modulo DEPTH.
REQ-019 SHALL drive in_ready = (count < DEPTH) and not halt and not flush; no push-through when full, even with out_ready=1.
REQ-020 SHALL push on in_valid and in_ready; SHALL pop on out_valid and out_ready; a simultaneous push and pop SHALL leave count unchanged.
REQ-021 SHALL drive out_valid = (count > 0) and not halt and not flush.
REQ-022 SHALL drive out_data, out_ctrl and out_flags to all-zero whenever out_valid=0.
REQ-023 SHALL present an entry accepted at edge N as the head no earlier than the cycle after edge N (1-cycle latency); order SHALL be strictly FIFO.
REQ-024 SHALL, while halt=1, change no state: pointers, count, entries and stall_cnt hold.
REQ-025 SHALL, on flush=1 at an edge with rst=1, set count and both pointers to 0; any entry offered that cycle is dropped; flush overrides halt.
REQ-026 SHALL increment stall_cnt by 1 per edge with out_valid=1 and out_ready=0, saturating at 0xFFFF; flush SHALL NOT clear it.
REQ-027 SHALL NOT reset the entry storage; only the control state is reset.

Reset
REQ-028 SHALL, at an edge with rst=0, set count=0, both pointers=0 and stall_cnt=0; rst overrides flush and halt.
REQ-029 SHALL hold in_ready=0 and out_valid=0 in the cycle following a reset edge only if halt or flush is asserted; otherwise in_ready=1 and out_valid=0.
REQ-030 SHALL, when reset is applied mid-operation, discard all held entries with no output pulse.

Configuration
REQ-031 SHALL provide a bypass path, compiled in by macro PIPE_STAGE_FIFO_BYPASS_EN.
REQ-032 With PIPE_STAGE_FIFO_BYPASS_EN defined, SHALL, when count=0, in_valid=1, halt=0 and flush=0, drive out_valid=1 and out_* = in_* combinationally (0-cycle latency).
REQ-033 With PIPE_STAGE_FIFO_BYPASS_EN defined, a bypassed entry with out_ready=1 SHALL NOT be stored; with out_ready=0 it SHALL be stored normally.
REQ-034 Without PIPE_STAGE_FIFO_BYPASS_EN, SHALL have no combinational path from the in_* ports to the out_* ports, with latency per REQ-023.

Verification
REQ-035 Bench SHALL cover: DEPTH=2, out_ready=0, push A=0x1, B=0x2, C=0x3 on consecutive cycles -> count=2, in_ready=0 on the third cycle, C not accepted.
REQ-036 Bench SHALL cover: full buffer, out_ready=1 for 2 cycles -> out_data A then B, then out_valid=0 and out_data=0.
REQ-037 Bench SHALL cover: DEPTH=4, 10 pushes with continuous pops -> output order preserved across pointer wrap, count never exceeds 1.
REQ-038 Bench SHALL cover: 2 held entries, flush with halt=1 and in_valid=1 -> next cycle count=0, out_valid=0, offered entry absent.
REQ-039 Bench SHALL cover: out_valid=1 with out_ready=0 for 70000 cycles -> stall_cnt=0xFFFF; rst=0 for one edge -> stall_cnt=0, count=0.
REQ-040 Bench SHALL cover: with PIPE_STAGE_FIFO_BYPASS_EN, empty buffer, in_valid=1, in_data=0xAB, out_ready=1 -> out_valid=1 and out_data=0xAB in the same cycle, count stays 0.
